// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and small helpers.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

   // Caller narrows the 32-bit result to its own requester count.
   function automatic logic [31:0] onehot(input int idx, input int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) begin
         if ((i == idx) && (i < n)) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               any_valid,
   output logic [IDX_W-1:0]   next
);

   logic [IDX_W-1:0] cand;

   // Scan farthest to nearest so the closest candidate after 'last' wins.
   always_comb begin
      any_valid = |req;
      next      = '0;
      cand      = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = IDX_W'((int'(last) + off) % NUM_REQ);
         if (req[cand]) next = cand;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter feeding the single write port of the FIFO.
// Optional per-requester beat counters on output beat_count when ARB_STATS_EN is defined.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            grant,
   input  logic                          fifo_full,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          fifo_wr_en
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]         beat_count
`endif
);

   localparam int IDX_W = idx_w(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] RST_LAST  = IDX_W'(NUM_REQ - 1);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;

   logic             any_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_valid;
   logic             accept;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req       (req_valid),
      .last      (last_q),
      .any_valid (any_valid),
      .next      (pick_idx)
   );

   assign owner_valid = req_valid[owner_q];
   assign accept      = (state_q == GRANT) && owner_valid && !fifo_full;
   assign fifo_wr_en  = accept;
   assign grant       = grant_q;

   always_comb begin
      req_ready = '0;
      fifo_din  = '0;
      if (state_q == GRANT) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
               req_ready[i] = !fifo_full;
               fifo_din     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      grant_d    = grant_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               owner_d    = pick_idx;
               grant_d    = NUM_REQ'(onehot(int'(pick_idx), NUM_REQ));
               beat_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            // A dropped valid releases immediately; a full FIFO simply stalls the burst.
            if ((accept && (beat_cnt_q == LAST_BEAT)) || !owner_valid) begin
               state_d    = IDLE;
               last_d     = owner_q;
               grant_d    = '0;
               beat_cnt_d = '0;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         last_q     <= RST_LAST;
         beat_cnt_q <= '0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
         grant_q    <= grant_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] stat_cnt_q [NUM_REQ];

   // Counters saturate rather than wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) stat_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (owner_q == IDX_W'(i)) && (stat_cnt_q[i] != 16'hFFFF))
               stat_cnt_q[i] <= stat_cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      beat_count = '0;
      for (int i = 0; i < NUM_REQ; i++) beat_count[i*16 +: 16] = stat_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-2 FIFO model on the write side.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [3:0]  grant;
   logic        fifo_full;
   logic [7:0]  fifo_din;
   logic        fifo_wr_en;
`ifdef ARB_STATS_EN
   logic [63:0] beat_count;
`endif

   logic        rd_en;
   logic [1:0]  fcount;
   logic [7:0]  base [4];
   logic [7:0]  nb [4];
   logic [7:0]  wlog [$];

   int n_chk  = 0;
   int n_fail = 0;

   logic [3:0] gexp [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                             4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                             4'b0001};
   logic [7:0] dexp [8]  = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};

   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .grant      (grant),
      .fifo_full  (fifo_full),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en)
`ifdef ARB_STATS_EN
      ,
      .beat_count (beat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_full = (fcount == 2'd2);

   always_comb begin
      for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base[i] + nb[i];
   end

   // Each requester advances its beat index when a beat transfers.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) nb[i] <= 8'd0;
      end else begin
         for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) nb[i] <= nb[i] + 8'd1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) fcount <= 2'd0;
      else fcount <= fcount + {1'b0, fifo_wr_en} - {1'b0, (rd_en && (fcount != 2'd0))};
   end

   always @(posedge clk) begin
      if (!rst && fifo_wr_en && !fifo_full) wlog.push_back(fifo_din);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'b0000;
      rd_en     = 1'b1;
      @(negedge clk);
      wlog.delete();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'b0000;
      rd_en     = 1'b1;
      for (int i = 0; i < 4; i++) base[i] = 8'h00;

      // 1: reset values, then single requester with one-cycle arbitration latency
      @(negedge clk);
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_wr_en", 64'(fifo_wr_en), 64'h0);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_din", 64'(fifo_din), 64'h0);
      rst       = 1'b0;
      base[0]   = 8'h11;
      req_valid = 4'b0001;
      #1;
      chk("t1_ready_same_cycle", 64'(req_ready), 64'h0);
      chk("t1_wr_same_cycle", 64'(fifo_wr_en), 64'h0);
      @(negedge clk);
      chk("t1_grant", 64'(grant), 64'h1);
      chk("t1_wr_en", 64'(fifo_wr_en), 64'h1);
      chk("t1_din", 64'(fifo_din), 64'h11);
      @(negedge clk);
      chk("t1_nwrites", 64'(wlog.size()), 64'd1);
      chk("t1_wdata", 64'(wlog[0]), 64'h11);
      req_valid = 4'b0000;
      @(negedge clk);
      chk("t1_release", 64'(grant), 64'h0);

      // 2: all requesters streaming, two-beat bursts with a bubble between grants
      do_reset();
      for (int i = 0; i < 4; i++) base[i] = 8'(i * 16);
      req_valid = 4'b1111;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         chk($sformatf("t2_grant_%0d", k), 64'(grant), 64'(gexp[k]));
      end
      req_valid = 4'b0000;
      @(negedge clk);
      chk("t2_nwrites", 64'(wlog.size()), 64'd8);
      for (int k = 0; k < 8; k++) chk($sformatf("t2_wdata_%0d", k), 64'(wlog[k]), 64'(dexp[k]));
`ifdef ARB_STATS_EN
      chk("t2_beat_count", beat_count, {16'd2, 16'd2, 16'd2, 16'd2});
`endif

      // 3: back-pressure from a full FIFO holds the grant and the beat count
      do_reset();
      base[1]   = 8'hA0;
      rd_en     = 1'b0;
      req_valid = 4'b0010;
      @(negedge clk);
      chk("t3_grant", 64'(grant), 64'h2);
      chk("t3_din0", 64'(fifo_din), 64'hA0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_full", 64'(fifo_full), 64'h1);
      chk("t3_burst_release", 64'(grant), 64'h0);
      @(negedge clk);
      chk("t3_regrant", 64'(grant), 64'h2);
      chk("t3_ready_full", 64'(req_ready), 64'h0);
      chk("t3_wr_full", 64'(fifo_wr_en), 64'h0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_grant_held", 64'(grant), 64'h2);
      chk("t3_nwrites2", 64'(wlog.size()), 64'd2);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("t3_ready_room", 64'(req_ready), 64'h2);
      chk("t3_wr_room", 64'(fifo_wr_en), 64'h1);
      chk("t3_din2", 64'(fifo_din), 64'hA2);
      @(negedge clk);
      chk("t3_full_again", 64'(fifo_full), 64'h1);
      chk("t3_wr_stall", 64'(fifo_wr_en), 64'h0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_nwrites3", 64'(wlog.size()), 64'd3);
      chk("t3_wdata2", 64'(wlog[2]), 64'hA2);
      chk("t3_grant_held2", 64'(grant), 64'h2);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("t3_din3", 64'(fifo_din), 64'hA3);
      @(negedge clk);
      chk("t3_cnt_held_release", 64'(grant), 64'h0);

      // 4: owner drops valid mid-burst, next requester granted after one bubble
      do_reset();
      base[2]   = 8'hC0;
      base[3]   = 8'hD0;
      req_valid = 4'b1100;
      @(negedge clk);
      chk("t4_grant2", 64'(grant), 64'h4);
      @(negedge clk);
      chk("t4_nwrites", 64'(wlog.size()), 64'd1);
      chk("t4_wdata", 64'(wlog[0]), 64'hC0);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("t4_bubble_grant", 64'(grant), 64'h0);
      chk("t4_bubble_wr", 64'(fifo_wr_en), 64'h0);
      @(negedge clk);
      chk("t4_grant3", 64'(grant), 64'h8);
      chk("t4_din3", 64'(fifo_din), 64'hD0);

      // 5: asynchronous reset mid-burst, then priority restarts at requester 0
      do_reset();
      base[2]   = 8'hC0;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t5_grant2", 64'(grant), 64'h4);
      chk("t5_wr_before", 64'(fifo_wr_en), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_grant", 64'(grant), 64'h0);
      chk("t5_async_wr", 64'(fifo_wr_en), 64'h0);
      chk("t5_async_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
      chk("t5_no_write", 64'(wlog.size()), 64'd0);
      rst       = 1'b0;
      req_valid = 4'b1111;
      @(negedge clk);
      chk("t5_first_prio", 64'(grant), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
